// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host handshake and SPI wire bundle for spi_master (optional abort via SPI_MASTER_ABORT_EN)
interface spi_master_if #(
    parameter int MSG_BITS = 8
);
    logic                start;
    logic [0:MSG_BITS-1] tx_data;
    logic                busy;
    logic                done;
    logic [0:MSG_BITS-1] rx_data;
    logic                sclk;
    logic                chip_enable;
    logic                mosi_bit;
    logic                miso_bit;
`ifdef SPI_MASTER_ABORT_EN
    logic                abort;
    logic                aborted;

    modport master (
        input  start, tx_data, miso_bit, abort,
        output busy, done, rx_data, sclk, chip_enable, mosi_bit, aborted
    );
    modport slave (
        output start, tx_data, miso_bit, abort,
        input  busy, done, rx_data, sclk, chip_enable, mosi_bit, aborted
    );
`else
    modport master (
        input  start, tx_data, miso_bit,
        output busy, done, rx_data, sclk, chip_enable, mosi_bit
    );
    modport slave (
        output start, tx_data, miso_bit,
        input  busy, done, rx_data, sclk, chip_enable, mosi_bit
    );
`endif
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 full-duplex master, index 0 first; SPI_MASTER_ABORT_EN adds abort/aborted
module spi_master #(
    parameter int MSG_BITS = 8,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 1
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    localparam int BIT_W  = $clog2(MSG_BITS + 1);
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CS_W   = $clog2(CS_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD} state_t;

    state_t              state;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [CS_W-1:0]     cs_cnt;
    logic [0:MSG_BITS-1] tx_sr;
    logic [0:MSG_BITS-1] rx_sr;
    logic [0:MSG_BITS-1] tx_shift;
    logic [0:MSG_BITS-1] rx_shift;

    // Index 0 is the MSB of an ascending vector, so a left shift walks
    // the next bit into position 0 and frees the last index for miso.
    assign tx_shift = tx_sr << 1;

    always_comb begin
        rx_shift             = rx_sr << 1;
        rx_shift[MSG_BITS-1] = bus.miso_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            div_cnt         <= '0;
            cs_cnt          <= '0;
            tx_sr           <= '0;
            rx_sr           <= '0;
            bus.sclk        <= 1'b0;
            bus.chip_enable <= 1'b1;
            bus.mosi_bit    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.rx_data     <= '0;
`ifdef SPI_MASTER_ABORT_EN
            bus.aborted     <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
`ifdef SPI_MASTER_ABORT_EN
            bus.aborted <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx_sr           <= bus.tx_data;
                        bus.mosi_bit    <= bus.tx_data[0];
                        bus.chip_enable <= 1'b0;
                        bus.busy        <= 1'b1;
                        cs_cnt          <= '0;
                        state           <= SETUP;
                    end
                end
                SETUP: begin
                    if (cs_cnt == CS_W'(CS_SETUP - 1)) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= LOW;
                    end else begin
                        cs_cnt <= cs_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        bus.sclk <= 1'b1;
                        rx_sr    <= rx_shift;
                        div_cnt  <= '0;
                        state    <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        bus.sclk <= 1'b0;
                        div_cnt  <= '0;
                        if (bit_cnt == BIT_W'(MSG_BITS - 1)) begin
                            cs_cnt <= '0;
                            state  <= HOLD;
                        end else begin
                            bit_cnt      <= bit_cnt + 1'b1;
                            tx_sr        <= tx_shift;
                            bus.mosi_bit <= tx_shift[0];
                            state        <= LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cs_cnt == CS_W'(CS_HOLD - 1)) begin
                        bus.chip_enable <= 1'b1;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.rx_data     <= rx_sr;
                        state           <= IDLE;
                    end else begin
                        cs_cnt <= cs_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef SPI_MASTER_ABORT_EN
            // Abort overrides whatever the active state scheduled, including done.
            if (bus.abort && state != IDLE) begin
                state           <= IDLE;
                bus.sclk        <= 1'b0;
                bus.chip_enable <= 1'b1;
                bus.busy        <= 1'b0;
                bus.done        <= 1'b0;
                bus.aborted     <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master (8-bit default and 768-bit CLK_DIV=1 loopback)
module tb_spi_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    spi_master_if #(.MSG_BITS(8))   sm ();
    spi_master_if #(.MSG_BITS(768)) bg ();

    spi_master dut_s (.clk(clk), .rst(rst), .bus(sm));
    spi_master #(.MSG_BITS(768), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1))
        dut_b (.clk(clk), .rst(rst), .bus(bg));

    assign bg.miso_bit = bg.mosi_bit;

    // Slave model: presents word bit k after the k-th sclk rise, records mosi at each rise.
    logic [0:7] slv_word = '0;
    logic [0:7] mosi_rec = '0;
    int         idx      = 0;
    logic       prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (sm.chip_enable) begin
            idx = 0;
            sm.miso_bit = slv_word[0];
        end else if (sm.sclk && !prev_sclk) begin
            if (idx < 8) mosi_rec[3'(idx)] = sm.mosi_bit;
            idx = idx + 1;
            if (idx < 8) sm.miso_bit = slv_word[3'(idx)];
        end
        prev_sclk = sm.sclk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Runs one 8-bit frame; returns at the negedge where done is seen (or on timeout).
    task automatic run8(input logic [0:7] tx, input logic [0:7] sw, input bit hold_start,
                        output int ce_low, output int rises, output int dones);
        logic ps;
        slv_word = sw;
        sm.tx_data = tx;
        sm.start = 1'b1;
        ce_low = 0; rises = 0; dones = 0; ps = 1'b0;
        @(negedge clk);
        if (!hold_start) sm.start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!sm.chip_enable) ce_low++;
            if (sm.sclk && !ps) rises++;
            ps = sm.sclk;
            if (sm.done) begin
                dones++;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [0:7] tx;
        logic [0:7] sw;
        logic [0:7] exp_rx;
    } vec_t;

    vec_t       vecs[5];
    int         ce_low, rises, dones;
    logic [0:7] prev_rx;
    logic [0:767] big_tx;

    initial begin
        sm.start = 1'b0; sm.tx_data = '0; sm.miso_bit = 1'b0;
        bg.start = 1'b0; bg.tx_data = '0;
`ifdef SPI_MASTER_ABORT_EN
        sm.abort = 1'b0; bg.abort = 1'b0;
`endif
        vecs[0] = '{8'h5C, 8'h5C, 8'h5C};
        vecs[1] = '{8'h5C, 8'hA2, 8'hA2};
        vecs[2] = '{8'h00, 8'hFF, 8'hFF};
        vecs[3] = '{8'hFF, 8'h00, 8'h00};
        vecs[4] = '{8'hA5, 8'h3C, 8'h3C};

        repeat (3) @(negedge clk);
        chk("rst_sclk", 64'(sm.sclk), 64'd0);
        chk("rst_ce", 64'(sm.chip_enable), 64'd1);
        chk("rst_mosi", 64'(sm.mosi_bit), 64'd0);
        chk("rst_busy", 64'(sm.busy), 64'd0);
        chk("rst_done", 64'(sm.done), 64'd0);
        chk("rst_rx", 64'(sm.rx_data), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run8(vecs[i].tx, vecs[i].sw, 1'b0, ce_low, rises, dones);
            chk($sformatf("vec%0d_done", i), 64'(dones), 64'd1);
            chk($sformatf("vec%0d_rx", i), 64'(sm.rx_data), 64'(vecs[i].exp_rx));
            chk($sformatf("vec%0d_mosi", i), 64'(mosi_rec), 64'(vecs[i].tx));
            chk($sformatf("vec%0d_ce_low", i), 64'(ce_low), 64'd34);
            chk($sformatf("vec%0d_rises", i), 64'(rises), 64'd8);
            repeat (2) @(negedge clk);
        end

        for (int i = 0; i < 8; i++) begin
            logic [0:7] tx, sw;
            tx = 8'($urandom);
            sw = 8'($urandom);
            run8(tx, sw, 1'b0, ce_low, rises, dones);
            chk($sformatf("rnd%0d_done", i), 64'(dones), 64'd1);
            chk($sformatf("rnd%0d_rx", i), 64'(sm.rx_data), 64'(sw));
            chk($sformatf("rnd%0d_mosi", i), 64'(mosi_rec), 64'(tx));
            chk($sformatf("rnd%0d_ce_low", i), 64'(ce_low), 64'd34);
            chk($sformatf("rnd%0d_busy_end", i), 64'(sm.busy), 64'd0);
            repeat (1 + $urandom_range(0, 3)) @(negedge clk);
        end

        // Back-to-back: start held across done, then start pulses while busy.
        run8(8'h96, 8'h69, 1'b1, ce_low, rises, dones);
        chk("b2b_first_done", 64'(dones), 64'd1);
        chk("b2b_ce_high_at_done", 64'(sm.chip_enable), 64'd1);
        @(negedge clk);
        chk("b2b_ce_low_next", 64'(sm.chip_enable), 64'd0);
        chk("b2b_busy_next", 64'(sm.busy), 64'd1);
        sm.start = 1'b0;
        slv_word = 8'h3A;
        ce_low = 0; dones = 0;
        for (int c = 0; c < 200; c++) begin
            if (!sm.chip_enable) ce_low++;
            if (sm.done) begin dones++; break; end
            sm.start = (c == 10 || c == 20);
            @(negedge clk);
        end
        sm.start = 1'b0;
        chk("b2b_second_done", 64'(dones), 64'd1);
        chk("b2b_second_ce_low", 64'(ce_low), 64'd34);
        chk("b2b_second_rx", 64'(sm.rx_data), 64'h3A);
        ce_low = 0; dones = 0;
        repeat (60) begin
            @(negedge clk);
            if (!sm.chip_enable) ce_low++;
            if (sm.done) dones++;
        end
        chk("busy_start_no_frame", 64'(ce_low), 64'd0);
        chk("busy_start_no_done", 64'(dones), 64'd0);

`ifdef SPI_MASTER_ABORT_EN
        prev_rx = sm.rx_data;
        slv_word = 8'hC3;
        sm.tx_data = 8'h11;
        sm.start = 1'b1;
        @(negedge clk);
        sm.start = 1'b0;
        rises = 0;
        begin
            logic ps;
            ps = 1'b0;
            for (int c = 0; c < 200 && rises < 5; c++) begin
                @(negedge clk);
                if (sm.sclk && !ps) rises++;
                ps = sm.sclk;
            end
        end
        chk("abort_reached_bit4", 64'(rises), 64'd5);
        sm.abort = 1'b1;
        @(negedge clk);
        sm.abort = 1'b0;
        chk("abort_pulse", 64'(sm.aborted), 64'd1);
        chk("abort_ce", 64'(sm.chip_enable), 64'd1);
        chk("abort_sclk", 64'(sm.sclk), 64'd0);
        chk("abort_busy", 64'(sm.busy), 64'd0);
        chk("abort_rx_kept", 64'(sm.rx_data), 64'(prev_rx));
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (sm.done) dones++;
        end
        chk("abort_pulse_end", 64'(sm.aborted), 64'd0);
        chk("abort_no_done", 64'(dones), 64'd0);
`endif

        // 768-bit loopback with CLK_DIV=1.
        for (int i = 0; i < 24; i++) big_tx[i*32 +: 32] = $urandom;
        bg.tx_data = big_tx;
        bg.start = 1'b1;
        @(negedge clk);
        bg.start = 1'b0;
        ce_low = 0; dones = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!bg.chip_enable) ce_low++;
            if (bg.done) begin dones++; break; end
            @(negedge clk);
        end
        chk("big_done", 64'(dones), 64'd1);
        chk("big_ce_low", 64'(ce_low), 64'd1538);
        chk("big_rx_eq_tx", 64'(bg.rx_data == big_tx), 64'd1);
        repeat (2) @(negedge clk);

        // Asynchronous reset at the third sclk rise.
        slv_word = 8'hE7;
        sm.tx_data = 8'h42;
        sm.start = 1'b1;
        @(negedge clk);
        sm.start = 1'b0;
        rises = 0;
        begin
            logic ps;
            ps = 1'b0;
            for (int c = 0; c < 200 && rises < 3; c++) begin
                @(negedge clk);
                if (sm.sclk && !ps) rises++;
                ps = sm.sclk;
            end
        end
        chk("rst_mid_reached_rise3", 64'(rises), 64'd3);
        chk("rst_mid_prev_rx_nonzero", 64'(sm.rx_data != 8'h00), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_sclk", 64'(sm.sclk), 64'd0);
        chk("rst_mid_ce", 64'(sm.chip_enable), 64'd1);
        chk("rst_mid_busy", 64'(sm.busy), 64'd0);
        chk("rst_mid_rx", 64'(sm.rx_data), 64'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (sm.done) dones++;
        end
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (sm.done) dones++;
        end
        chk("rst_mid_no_done", 64'(dones), 64'd0);
        chk("rst_mid_rx_after", 64'(sm.rx_data), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
